// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serial framer that sends each accepted word as one frame,
// made of the sync word 4'b1011 followed by the payload, one bit per bit period.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   data_in      in   payload word, sampled on the valid/ready handshake
//   data_valid   in   data_in is valid; held until accepted
//   data_ready   out  block is idle and out of reset (decoded, not registered)
//   ser_out      out  serial line, held for the whole bit period
//   ser_en       out  strobe on the first clk of each bit period
//   frame_start  out  pulse with ser_en of the first sync bit
//   frame_done   out  pulse with ser_en of the last bit of the frame
//   busy         out  high in every state except IDLE
//
// Optional macro SYNC_FRAME_TX_STUFF_EN: when defined, a stuff 0 is sent after
// any payload bit that leaves the last three line bits at 101, so 1011 can
// never reappear after the sync word. Undefined: frames are 4+DATA_W bits.
module sync_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int BIT_DIV   = 1,
    parameter int GAP       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ser_out,
    output logic              ser_en,
    output logic              frame_start,
    output logic              frame_done,
    output logic              busy
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CW_D  = $clog2(DATA_W + 1);
    localparam int CW_G  = $clog2(GAP + 1);
    localparam int CW_M  = (CW_D > CW_G) ? CW_D : CW_G;
    // The same counter indexes sync bits (0..3), payload bits and gap periods.
    localparam int CNT_W = (CW_M > 2) ? CW_M : 2;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(3);
    localparam logic [DIV_W-1:0] LAST_DIV  = DIV_W'(BIT_DIV - 1);
    localparam logic [3:0]       SYNC_WORD = 4'b1011;

`ifdef SYNC_FRAME_TX_STUFF_EN
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_GAP} state_t;
`endif

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DIV_W-1:0]  div, div_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              ser_out_n, ser_en_n, fs_n, fd_n;
    logic              tc, pay_bit, send_pay, frame_end;
    logic [DATA_W-1:0] pay_shift;
    logic [1:0]        sync_idx;
`ifdef SYNC_FRAME_TX_STUFF_EN
    logic [2:0]        hist, hist_n;
`endif

    assign tc         = (div == LAST_DIV);
    assign data_ready = (state == S_IDLE) & ~rst;
    // While sync bit cnt is on the line, the next one is SYNC_WORD[3-(cnt+1)].
    assign sync_idx   = 2'd2 - cnt[1:0];

    always_comb begin
        if (MSB_FIRST != 0) begin
            pay_bit   = shreg[DATA_W-1];
            pay_shift = shreg << 1;
        end else begin
            pay_bit   = shreg[0];
            pay_shift = shreg >> 1;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        div_n     = div;
        shreg_n   = shreg;
        ser_out_n = ser_out;
        ser_en_n  = 1'b0;
        fs_n      = 1'b0;
        fd_n      = 1'b0;
        send_pay  = 1'b0;
        frame_end = 1'b0;
`ifdef SYNC_FRAME_TX_STUFF_EN
        hist_n    = hist;
`endif
        if (state != S_IDLE)
            div_n = tc ? '0 : div + 1'b1;
        case (state)
            S_IDLE: begin
                if (data_valid) begin
                    state_n   = S_SYNC;
                    cnt_n     = '0;
                    shreg_n   = data_in;
                    ser_out_n = 1'b1;
                    ser_en_n  = 1'b1;
                    fs_n      = 1'b1;
`ifdef SYNC_FRAME_TX_STUFF_EN
                    hist_n    = 3'b001;
`endif
                end
            end
            S_SYNC: begin
                if (tc) begin
                    if (cnt == LAST_SYNC) begin
                        cnt_n    = '0;
                        send_pay = 1'b1;
                    end else begin
                        cnt_n     = cnt + 1'b1;
                        ser_out_n = SYNC_WORD[sync_idx];
                        ser_en_n  = 1'b1;
`ifdef SYNC_FRAME_TX_STUFF_EN
                        hist_n    = {hist[1:0], SYNC_WORD[sync_idx]};
`endif
                    end
                end
            end
            S_DATA: begin
                if (tc) begin
`ifdef SYNC_FRAME_TX_STUFF_EN
                    if (hist == 3'b101) begin
                        state_n   = S_STUFF;
                        ser_out_n = 1'b0;
                        ser_en_n  = 1'b1;
                        fd_n      = (cnt == LAST_BIT);
                        hist_n    = {hist[1:0], 1'b0};
                    end else if (cnt == LAST_BIT) begin
                        frame_end = 1'b1;
                    end else begin
                        cnt_n    = cnt + 1'b1;
                        send_pay = 1'b1;
                    end
`else
                    if (cnt == LAST_BIT) begin
                        frame_end = 1'b1;
                    end else begin
                        cnt_n    = cnt + 1'b1;
                        send_pay = 1'b1;
                    end
`endif
                end
            end
`ifdef SYNC_FRAME_TX_STUFF_EN
            S_STUFF: begin
                if (tc) begin
                    if (cnt == LAST_BIT) begin
                        frame_end = 1'b1;
                    end else begin
                        cnt_n    = cnt + 1'b1;
                        send_pay = 1'b1;
                    end
                end
            end
`endif
            S_GAP: begin
                if (tc) begin
                    if (cnt == LAST_GAP)
                        state_n = S_IDLE;
                    else
                        cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (send_pay) begin
            state_n   = S_DATA;
            ser_out_n = pay_bit;
            ser_en_n  = 1'b1;
            shreg_n   = pay_shift;
            fd_n      = (cnt_n == LAST_BIT);
`ifdef SYNC_FRAME_TX_STUFF_EN
            hist_n    = {hist[1:0], pay_bit};
            // A trailing stuff bit takes over the frame_done marker.
            if (hist_n == 3'b101)
                fd_n = 1'b0;
`endif
        end
        if (frame_end) begin
            cnt_n     = '0;
            ser_out_n = 1'b0;
            state_n   = (GAP == 0) ? S_IDLE : S_GAP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            div         <= '0;
            shreg       <= '0;
            ser_out     <= 1'b0;
            ser_en      <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
`ifdef SYNC_FRAME_TX_STUFF_EN
            hist        <= '0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            div         <= div_n;
            shreg       <= shreg_n;
            ser_out     <= ser_out_n;
            ser_en      <= ser_en_n;
            frame_start <= fs_n;
            frame_done  <= fd_n;
            busy        <= (state_n != S_IDLE);
`ifdef SYNC_FRAME_TX_STUFF_EN
            hist        <= hist_n;
`endif
        end
    end

endmodule
